gba_bus_ctrl: RTL and testbench

Memory-side bus controller directly downstream of the ARMv4T core. It serves the core's single outstanding read/write request (addr, width, read/write strobes, ok handshake) and decodes the GBA address map into a region-tagged word RAM port. It applies per-region wait states, byte-lane steering and load-data alignment. The top level splits the core's shared addr/data bus into the separate in/out ports used here.

---
 rtl/gba_bus_pkg.sv | 64 ++++++
 rtl/gba_lane_fmt.sv | 41 ++++
 rtl/gba_bus_ctrl.sv | 159 +++++++++++++++
 tb/tb_gba_bus_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gba_bus_pkg.sv
// Shared types and address-map constants for the GBA memory-side bus controller.
// Used by gba_bus_ctrl (optional GBA_BUS_ERR_EN error reporting) and gba_lane_fmt.
package gba_bus_pkg;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } width_e;

  typedef enum logic [1:0] {
    R_BIOS  = 2'd0,
    R_EWRAM = 2'd1,
    R_IWRAM = 2'd2,
    R_ROM   = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  localparam logic [3:0] BASE_BIOS   = 4'h0;
  localparam logic [3:0] BASE_EWRAM  = 4'h2;
  localparam logic [3:0] BASE_IWRAM  = 4'h3;
  localparam logic [3:0] BASE_ROM_LO = 4'h8;
  localparam logic [3:0] BASE_ROM_HI = 4'hD;

  // Word-address masks; smaller regions mirror across their window.
  localparam logic [22:0] MASK_BIOS  = 23'h000FFF;
  localparam logic [22:0] MASK_EWRAM = 23'h00FFFF;
  localparam logic [22:0] MASK_IWRAM = 23'h001FFF;
  localparam logic [22:0] MASK_ROM   = 23'h7FFFFF;

  function automatic logic decode_mapped(input logic [3:0] nib);
    return (nib == BASE_BIOS) || (nib == BASE_EWRAM) || (nib == BASE_IWRAM) ||
           ((nib >= BASE_ROM_LO) && (nib <= BASE_ROM_HI));
  endfunction

  function automatic region_e decode_region(input logic [3:0] nib);
    region_e r;
    case (nib)
      BASE_BIOS:  r = R_BIOS;
      BASE_EWRAM: r = R_EWRAM;
      BASE_IWRAM: r = R_IWRAM;
      default:    r = R_ROM;
    endcase
    return r;
  endfunction

  function automatic logic [22:0] region_mask(input region_e r);
    logic [22:0] m;
    case (r)
      R_BIOS:  m = MASK_BIOS;
      R_EWRAM: m = MASK_EWRAM;
      R_IWRAM: m = MASK_IWRAM;
      default: m = MASK_ROM;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gba_lane_fmt.sv
// Combinational byte-lane steering: byte enables, store replication and load alignment.
// Shared between the CPU bus controller and the DMA engine.
module gba_lane_fmt
  import gba_bus_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [63:0] w_dbl;
  logic [5:0]  w_sh;

  assign w_dbl = {i_rdata, i_rdata};
  assign w_sh  = {1'b0, i_addr_lo, 3'b000};

  always_comb begin
    o_be    = 4'hF;
    o_wdata = i_wdata;
    // Word loads rotate right so unaligned LDR matches ARM behaviour.
    o_rdata = w_dbl[w_sh +: 32];
    case (i_width)
      W_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'h0, w_dbl[w_sh +: 8]};
      end
      W_HALF: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {16'h0, (i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0])};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gba_bus_ctrl.sv
// GBA bus controller: one outstanding CPU request, region decode, wait states, lane steering.
// Define GBA_BUS_ERR_EN to add bus_err/err_addr reporting of unmapped and read-only writes.
module gba_bus_ctrl
  import gba_bus_pkg::*;
#(
  parameter int WS_BIOS  = 0,
  parameter int WS_EWRAM = 2,
  parameter int WS_IWRAM = 0,
  parameter int WS_ROM   = 4,
  parameter int WS_W     = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ok,
  output logic        ram_en,
  output logic        ram_we,
  output logic [1:0]  ram_region,
  output logic [22:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
`ifdef GBA_BUS_ERR_EN
  ,
  output logic        bus_err,
  output logic [31:0] err_addr
`endif
);

  state_e          r_state;
  state_e          w_next;
  logic [WS_W-1:0] r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [1:0]      r_width;
  logic            r_write;

  logic            w_req;
  logic [WS_W-1:0] w_ws;
  logic            w_mapped;
  region_e         w_region;
  logic            w_ram_ok;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata_rep;
  logic [31:0]     w_rdata_fmt;

  assign w_req = cpu_read | cpu_write;

  // Wait states come from the incoming address; unmapped space costs none.
  always_comb begin
    w_ws = '0;
    if (decode_mapped(cpu_addr[27:24])) begin
      case (decode_region(cpu_addr[27:24]))
        R_BIOS:  w_ws = WS_W'(WS_BIOS);
        R_EWRAM: w_ws = WS_W'(WS_EWRAM);
        R_IWRAM: w_ws = WS_W'(WS_IWRAM);
        default: w_ws = WS_W'(WS_ROM);
      endcase
    end
  end

  assign w_mapped = decode_mapped(r_addr[27:24]);
  assign w_region = decode_region(r_addr[27:24]);
  assign w_ram_ok = w_mapped &&
                    !(r_write && ((w_region == R_BIOS) || (w_region == R_ROM)));

  gba_lane_fmt u_lane_fmt (
    .i_width   (r_width),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (ram_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_rdata_fmt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req)
        r_cnt <= w_ws;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Request fields are frozen at acceptance; cpu_* is ignored until IDLE again.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_req) begin
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
      r_width <= cpu_width;
      r_write <= cpu_write;
    end
  end

  always_comb begin
    w_next     = r_state;
    cpu_ok     = 1'b0;
    cpu_rdata  = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_region = '0;
    ram_addr   = '0;
    ram_be     = '0;
    ram_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req)
          w_next = (w_ws == '0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt <= WS_W'(1))
          w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_next = S_RESP;
        if (w_ram_ok) begin
          ram_en     = 1'b1;
          ram_we     = r_write;
          ram_region = w_region;
          ram_addr   = r_addr[24:2] & region_mask(w_region);
          ram_be     = w_be;
          ram_wdata  = w_wdata_rep;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
        cpu_ok = 1'b1;
        if (w_mapped && !r_write)
          cpu_rdata = w_rdata_fmt;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef GBA_BUS_ERR_EN
  assign bus_err = (r_state == S_RESP) && !w_ram_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      err_addr <= '0;
    else if (r_state == S_ACCESS && !w_ram_ok)
      err_addr <= r_addr;
  end
`else
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^r_addr[31:28];
`endif

endmodule

// File: tb/tb_gba_bus_ctrl.sv
// Directed self-checking bench for gba_bus_ctrl (error ports checked when GBA_BUS_ERR_EN is set).
module tb_gba_bus_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic [1:0]  cpu_width, ram_region;
  logic        cpu_read, cpu_write, cpu_ok, ram_en, ram_we;
  logic [22:0] ram_addr;
  logic [3:0]  ram_be;
`ifdef GBA_BUS_ERR_EN
  logic        bus_err;
  logic [31:0] err_addr;
`endif

  always #5 clk = ~clk;

  gba_bus_ctrl dut (
    .clk(clk), .rstn(rstn),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_width(cpu_width),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_ok(cpu_ok),
    .ram_en(ram_en), .ram_we(ram_we), .ram_region(ram_region),
    .ram_addr(ram_addr), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef GBA_BUS_ERR_EN
    , .bus_err(bus_err), .err_addr(err_addr)
`endif
  );

  int checks   = 0;
  int failures = 0;

  int          s_en_cyc, s_ok_cyc, s_en_cnt;
  logic        s_we, s_ok_after, s_err;
  logic [1:0]  s_region;
  logic [22:0] s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wdata, s_rdata, s_err_addr;
  logic        s_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request; cycle k counts negedges after the accepting posedge.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [1:0] w, input logic [31:0] wd);
    s_en_cyc = 0; s_ok_cyc = 0; s_en_cnt = 0;
    s_we = 0; s_region = 0; s_addr = 0; s_be = 0; s_wdata = 0; s_rdata = 0;
    s_err = 0; s_err_addr = 0;
    @(negedge clk);
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_width = w; cpu_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= 20 && s_ok_cyc == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cpu_read = 0; cpu_write = 0; cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'hFFFF_FFFF;
      end
      if (ram_en) begin
        s_en_cnt++;
        if (s_en_cyc == 0) begin
          s_en_cyc = k; s_we = ram_we; s_region = ram_region; s_addr = ram_addr;
          s_be = ram_be; s_wdata = ram_wdata;
        end
      end
      if (cpu_ok) begin
        s_ok_cyc = k; s_rdata = cpu_rdata;
`ifdef GBA_BUS_ERR_EN
        s_err = bus_err; s_err_addr = err_addr;
`endif
      end
    end
    @(negedge clk);
    s_ok_after = cpu_ok | ram_en;
  endtask

  initial begin
    rstn = 0; cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0; cpu_width = 0;
    ram_rdata = 32'h0;
    #12;
    chk("rst_ok", cpu_ok, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_be", ram_be, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_rdata", cpu_rdata, 0);
`ifdef GBA_BUS_ERR_EN
    chk("rst_err_addr", err_addr, 0);
`endif
    @(negedge clk); rstn = 1;

    // Word read from IWRAM, no wait states.
    ram_rdata = 32'hDEADBEEF;
    run_req(1, 0, 32'h0300_0004, 2'd2, 0);
    chk("wr_iw_en_cyc", s_en_cyc, 1);
    chk("wr_iw_region", s_region, 2);
    chk("wr_iw_addr", s_addr, 1);
    chk("wr_iw_we", s_we, 0);
    chk("wr_iw_be", s_be, 4'hF);
    chk("wr_iw_ok_cyc", s_ok_cyc, 2);
    chk("wr_iw_rdata", s_rdata, 32'hDEADBEEF);
    chk("wr_iw_single", s_ok_after, 0);
    chk("wr_iw_en_cnt", s_en_cnt, 1);

    // Byte write into EWRAM mirror, two wait states.
    run_req(0, 1, 32'h0204_0003, 2'd0, 32'h0000_00A5);
    chk("bw_ew_en_cyc", s_en_cyc, 3);
    chk("bw_ew_we", s_we, 1);
    chk("bw_ew_region", s_region, 1);
    chk("bw_ew_addr", s_addr, 0);
    chk("bw_ew_be", s_be, 4'b1000);
    chk("bw_ew_wdata", s_wdata, 32'hA5A5A5A5);
    chk("bw_ew_ok_cyc", s_ok_cyc, 4);

    // Unaligned word read from ROM rotates the word.
    ram_rdata = 32'h11223344;
    run_req(1, 0, 32'h0800_0002, 2'd2, 0);
    chk("uw_rom_en_cyc", s_en_cyc, 5);
    chk("uw_rom_region", s_region, 3);
    chk("uw_rom_ok_cyc", s_ok_cyc, 6);
    chk("uw_rom_rdata", s_rdata, 32'h33441122);

    // Byte read from BIOS lane 1.
    run_req(1, 0, 32'h0000_0001, 2'd0, 0);
    chk("br_bios_be", s_be, 4'b0010);
    chk("br_bios_region", s_region, 0);
    chk("br_bios_rdata", s_rdata, 32'h0000_0033);

    // Half read upper halfword.
    ram_rdata = 32'hCAFE1234;
    run_req(1, 0, 32'h0300_0006, 2'd1, 0);
    chk("hr_be", s_be, 4'b1100);
    chk("hr_addr", s_addr, 1);
    chk("hr_rdata", s_rdata, 32'h0000CAFE);

    // Half write with addr[0] set (ignored).
    run_req(0, 1, 32'h0300_0001, 2'd1, 32'h0000_BEEF);
    chk("hw_be", s_be, 4'b0011);
    chk("hw_wdata", s_wdata, 32'hBEEFBEEF);

    // Width 3 behaves as word.
    ram_rdata = 32'h01020304;
    run_req(1, 0, 32'h0300_0008, 2'd3, 0);
    chk("w3_be", s_be, 4'hF);
    chk("w3_addr", s_addr, 2);
    chk("w3_rdata", s_rdata, 32'h01020304);

    // Read and write together: the write wins.
    run_req(1, 1, 32'h0300_000C, 2'd2, 32'h12345678);
    chk("rw_we", s_we, 1);
    chk("rw_wdata", s_wdata, 32'h12345678);

    // Address mirroring / range limits.
    run_req(1, 0, 32'h0000_7FFC, 2'd2, 0);
    chk("bios_mirror_addr", s_addr, 23'h000FFF);
    run_req(1, 0, 32'h0300_FFFC, 2'd2, 0);
    chk("iw_mirror_addr", s_addr, 23'h001FFF);
    run_req(1, 0, 32'h0DFF_FFFC, 2'd2, 0);
    chk("rom_top_addr", s_addr, 23'h7FFFFF);
    chk("rom_top_region", s_region, 3);

    // Write to ROM: no RAM strobe, still completes.
    run_req(0, 1, 32'h0800_0000, 2'd2, 32'h5555AAAA);
    chk("romw_no_en", s_en_cnt, 0);
    chk("romw_ok_seen", (s_ok_cyc > 0), 1);
`ifdef GBA_BUS_ERR_EN
    chk("romw_bus_err", s_err, 1);
    chk("romw_err_addr", s_err_addr, 32'h0800_0000);
`endif

    // Unmapped read returns zero without a RAM strobe.
    ram_rdata = 32'hFFFFFFFF;
    run_req(1, 0, 32'h0500_0000, 2'd2, 0);
    chk("unm_no_en", s_en_cnt, 0);
    chk("unm_ok_cyc", s_ok_cyc, 2);
    chk("unm_rdata", s_rdata, 0);
`ifdef GBA_BUS_ERR_EN
    chk("unm_bus_err", s_err, 1);
    chk("unm_err_addr", s_err_addr, 32'h0500_0000);
`endif

    // Reset asserted during the WAIT phase of a ROM read.
    @(negedge clk);
    cpu_read = 1; cpu_addr = 32'h0800_0000; cpu_width = 2'd2;
    @(negedge clk);
    cpu_read = 0;
    @(posedge clk);
    #2 rstn = 0;
    #1;
    chk("midrst_ok", cpu_ok, 0);
    chk("midrst_en", ram_en, 0);
    s_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cpu_ok || ram_en) s_bad = 1;
    end
    rstn = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_ok || ram_en) s_bad = 1;
    end
    chk("midrst_no_ok", s_bad, 0);
    ram_rdata = 32'hA1B2C3D4;
    run_req(1, 0, 32'h0300_0010, 2'd2, 0);
    chk("post_rst_ok_cyc", s_ok_cyc, 2);
    chk("post_rst_addr", s_addr, 4);
    chk("post_rst_rdata", s_rdata, 32'hA1B2C3D4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
